// File: rtl/sa_cache_pkg.sv
// Shared widths, entry layout, FSM states and address field helpers for the
// 2-way set-associative cache miss controller.
package sa_cache_pkg;

    localparam int ADDR_W     = 16;
    localparam int TAG_W      = 5;
    localparam int IDX_W      = 7;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 128;
    localparam int ENTRY_W    = 134;

    // Word w of a line lives at line[32*(3-w) +: 32], so word 0 is the MSW.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] line;
    } cache_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_BEAT,
        FILL,
        RESP
    } state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[15:11];
    endfunction

    function automatic logic [IDX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[10:4];
    endfunction

    function automatic logic [1:0] get_word(input logic [ADDR_W-1:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/sa_lru_table.sv
// Per-set LRU bits: the bit names the least recently used way, i.e. the
// next victim. Cleared synchronously while rst_n is low.
module sa_lru_table
    import sa_cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_bit_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_bit_i
);

    logic [(1<<IDX_W)-1:0] lru_q;

    // One bit per set; a single write port updated on hit or fill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (we_i) begin
            lru_q[wr_idx_i] <= wr_bit_i;
        end
    end

    assign rd_bit_o = lru_q[rd_idx_i];

endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// Request sequencer and refill engine for the 2-way cache lookup stage.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a CPU request; latch its address on req_valid
// LOOKUP   | sample lookup hit; hit -> RESP, miss -> pick victim, MEM_REQ
// MEM_REQ  | hold line read request until memory accepts it
// MEM_BEAT | collect 4 beats (word 0..3), capture requested word on the way
// FILL     | one-cycle write of the assembled entry into the victim way
// RESP     | one-cycle resp_valid pulse, then back to IDLE
module sa_cache_miss_ctrl
    import sa_cache_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int TAG_W      = 5,
    parameter int IDX_W      = 7,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [31:0]        resp_data,
    output logic [ADDR_W-1:0]  lookup_addr,
    input  logic               lookup_hit,
    input  logic               lookup_hit_way,
    input  logic [31:0]        lookup_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_data,
    output logic               fill_we,
    output logic               fill_way,
    output logic [IDX_W-1:0]   fill_index,
    output logic [ENTRY_W-1:0] fill_entry
);

    // Field slicing is hard-wired to the default geometry.
    if (ADDR_W != 16 || TAG_W != 5 || IDX_W != 7 || LINE_WORDS != 4) begin : g_param_check
        $error("sa_cache_miss_ctrl supports only ADDR_W=16, TAG_W=5, IDX_W=7, LINE_WORDS=4");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          beat_q, beat_d;
    logic                victim_q, victim_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic                lru_rd_bit;
    logic                lru_we;
    logic                lru_wr_bit;
    logic [IDX_W-1:0]    set_idx;
    cache_entry_t        entry;

    assign set_idx = get_index(addr_q);

    sa_lru_table u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx_i (set_idx),
        .rd_bit_o (lru_rd_bit),
        .we_i     (lru_we),
        .wr_idx_i (set_idx),
        .wr_bit_i (lru_wr_bit)
    );

    // State and datapath registers; reset also drops any partially built line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            beat_q      <= '0;
            victim_q    <= 1'b0;
            resp_data_q <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            victim_q    <= victim_d;
            resp_data_q <= resp_data_d;
            line_q      <= line_d;
        end
    end

    // Next-state, datapath updates, LRU writes and handshake outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        victim_d      = victim_q;
        resp_data_d   = resp_data_q;
        line_d        = line_q;
        lru_we        = 1'b0;
        lru_wr_bit    = 1'b0;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        fill_we       = 1'b0;
        resp_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    resp_data_d = lookup_data;
                    lru_we      = 1'b1;
                    lru_wr_bit  = ~lookup_hit_way;
                    state_d     = RESP;
                end else begin
                    victim_d = lru_rd_bit;
                    state_d  = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = 2'd0;
                    state_d = MEM_BEAT;
                end
            end
            MEM_BEAT: begin
                if (mem_rsp_valid) begin
                    // 3-beat == ~beat for a 2-bit counter, so the slot is pure slicing.
                    line_d[{~beat_q, 5'b00000} +: 32] = mem_rsp_data;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == get_word(addr_q)) begin
                        resp_data_d = mem_rsp_data;
                    end
                    if (beat_q == 2'd3) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                fill_we    = 1'b1;
                lru_we     = 1'b1;
                lru_wr_bit = ~victim_q;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        entry       = '0;
        entry.valid = 1'b1;
        entry.tag   = get_tag(addr_q);
        entry.line  = line_q;
    end

    // Fill bus is quiet outside the FILL cycle.
    assign fill_way     = (state_q == FILL) ? victim_q : 1'b0;
    assign fill_index   = (state_q == FILL) ? set_idx : '0;
    assign fill_entry   = (state_q == FILL) ? entry : '0;

    assign lookup_addr  = addr_q;
    assign mem_req_addr = {addr_q[ADDR_W-1:4], 4'b0000};
    assign resp_data    = resp_data_q;

endmodule
